// File: rtl/stopwatch.sv
// BCD stopwatch SS.hh (00.00-59.99) with a TICK_DIV-cycle prescaler
// and level-sensitive start/stop plus a synchronous clear.
module stopwatch #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [3:0] ms1,
  output logic [3:0] ms0
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST =
    PW'(TICK_DIV - 1);

  logic          running;
  logic [PW-1:0] pre;
  logic          tick;

  // registered running governs this edge, so a stop
  // edge still honours a tick that falls due on it
  assign tick = running && (pre == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      pre     <= '0;
      sec1    <= 4'd0;
      sec0    <= 4'd0;
      ms1     <= 4'd0;
      ms0     <= 4'd0;
    end else if (reset) begin
      running <= 1'b0;
      pre     <= '0;
      sec1    <= 4'd0;
      sec0    <= 4'd0;
      ms1     <= 4'd0;
      ms0     <= 4'd0;
    end else begin
      if (stop)
        running <= 1'b0;
      else if (start)
        running <= 1'b1;

      if (running)
        pre <= tick ? '0 : pre + PW'(1);

      if (tick) begin
        if (ms0 == 4'd9) begin
          ms0 <= 4'd0;
          if (ms1 == 4'd9) begin
            ms1 <= 4'd0;
            if (sec0 == 4'd9) begin
              sec0 <= 4'd0;
              if (sec1 == 4'd5)
                sec1 <= 4'd0;
              else
                sec1 <= sec1 + 4'd1;
            end else begin
              sec0 <= sec0 + 4'd1;
            end
          end else begin
            ms1 <= ms1 + 4'd1;
          end
        end else begin
          ms0 <= ms0 + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench for stopwatch: scripted vector table, then
// random control traffic against a hundredths-count reference model.
module tb_stopwatch;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sec1, sec0, ms1, ms0;

  int checks = 0;
  int errors = 0;

  // model: elapsed hundredths, run flag, cycles into current tick
  int m_run = 0;
  int m_pre = 0;
  int m_cnt = 0;

  stopwatch #(.TICK_DIV(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .reset(reset),
    .sec1 (sec1),
    .sec0 (sec0),
    .ms1  (ms1),
    .ms0  (ms0)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        rs;
    int          n;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t v[11];

  function automatic logic [15:0] bcd(int c);
    return {4'(c / 1000), 4'((c / 100) % 10),
            4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic chk(string nm, logic [15:0] exp);
    logic [15:0] got;
    got = {sec1, sec0, ms1, ms0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0;
    m_pre = 0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_clear();
    end else begin
      if (m_run != 0) begin
        if (m_pre == D - 1) begin
          m_pre = 0;
          m_cnt = (m_cnt + 1) % 6000;
        end else begin
          m_pre++;
        end
      end
      if (stop)
        m_run = 0;
      else if (start)
        m_run = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", bcd(m_cnt));
    checks++;
    if (sec1 > 4'd5) begin
      errors++;
      $display("FAIL sec1_range: got %0d expected <=5", sec1);
    end
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0, 251,   16'h0125, "count"};
    v[1]  = '{1'b0, 1'b1, 1'b0, 5,     16'h0125, "stop_hold"};
    v[2]  = '{1'b1, 1'b0, 1'b0, 1,     16'h0125, "start_pulse"};
    v[3]  = '{1'b0, 1'b0, 1'b0, 2,     16'h0126, "resume"};
    v[4]  = '{1'b1, 1'b0, 1'b1, 1,     16'h0000, "clear"};
    v[5]  = '{1'b0, 1'b0, 1'b0, 10,    16'h0000, "clear_idle"};
    v[6]  = '{1'b1, 1'b1, 1'b0, 10,    16'h0000, "start_stop"};
    v[7]  = '{1'b1, 1'b0, 1'b0, 1,     16'h0000, "restart"};
    v[8]  = '{1'b0, 1'b0, 1'b0, 11998, 16'h5999, "to_5999"};
    v[9]  = '{1'b0, 1'b0, 1'b0, 2,     16'h0000, "wrap"};
    v[10] = '{1'b0, 1'b0, 1'b0, 7,     16'h0003, "recount"};

    model_clear();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #10;
      chk("rst_hold", 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start = v[i].st;
      stop  = v[i].sp;
      reset = v[i].rs;
      repeat (v[i].n) step();
      chk(v[i].name, v[i].exp);
    end

    // asynchronous clear mid-count, away from any edge
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst", 16'h0000);
    model_clear();
    rst = 1'b1;
    repeat (6) step();
    chk("idle_after_rst", 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      step();
      if ($urandom_range(0, 299) == 0) begin
        #3;
        rst = 1'b0;
        #1;
        chk("rand_async_rst", 16'h0000);
        model_clear();
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch.md
# stopwatch

BCD stopwatch counting seconds and hundredths of a second (SS.hh, 00.00 to 59.99) from a single system clock. A parameterised prescaler derives the 10 ms tick. Level-sensitive start/stop/clear controls gate counting. The four BCD digit outputs drive a downstream 7-segment display multiplexer.

## Interface

Parameters:
- `TICK_DIV`, default 500000. Clock cycles per hundredth-second tick; the default gives 10 ms at 50 MHz. Legal range is ≥ 1.

Ports:
- `clk`, input, 1 bit. System clock; all logic is rising-edge.
- `rst`, input, 1 bit. Reset, asynchronous and active-low: when 0, all state clears immediately.
- `start`, input, 1 bit. Level; when sampled high, counting is enabled.
- `stop`, input, 1 bit. Level; when sampled high, counting is paused and the count is held.
- `reset`, input, 1 bit. Synchronous clear of the count, prescaler and run state; active-high.
- `sec1`, output, 4 bits. Seconds tens digit, BCD 0–5.
- `sec0`, output, 4 bits. Seconds units digit, BCD 0–9.
- `ms1`, output, 4 bits. Tenths digit, BCD 0–9.
- `ms0`, output, 4 bits. Hundredths digit, BCD 0–9.

## Operation

- State:
  - `running` flag (1 bit).
  - Prescaler `pre`: width clog2(TICK_DIV), minimum 1 bit.
  - Four 4-bit BCD digit registers, which drive the outputs directly with no output logic.
- Asynchronous reset (`rst`=0):
  - `running`=0, `pre`=0, all digits = 0.
  - Outputs read 0000 while `rst` is low.
- Control priority, evaluated each clock edge: `reset` > `stop` > `start`.
  - `reset`=1: `running`←0, `pre`←0, all digits ←0. This overrides any tick in the same cycle.
  - else `stop`=1: `running`←0. `pre` and the digits hold (pause, not clear).
  - else `start`=1: `running`←1. If already running, there is no effect; `pre` is not restarted.
  - none asserted: `running` holds.
- Prescaler, active only when `running`=1 and `reset`=0:
  - If `pre`==TICK_DIV−1: `pre`←0 and a tick occurs this edge.
  - Otherwise `pre`←`pre`+1.
  - When not running, `pre` holds.
- Tick increments the BCD chain:
  - `ms0` 0→9, wraps to 0 with carry to `ms1`.
  - `ms1` 0→9, wraps with carry to `sec0`.
  - `sec0` 0→9, wraps with carry to `sec1`.
  - `sec1` 0→5, wraps to 0.
  - 59.99 + tick → 00.00 (free-running wrap, no overflow flag).
- Digits never hold non-BCD values. Digits only change on a tick or on a clear.
- Resume after stop continues from the held `pre` value, so no partial-tick time is lost.

## Timing

- `start` is sampled high at edge k, so `running`=1 after edge k.
- `pre` first increments at edge k+1.
- First tick occurs at edge k+TICK_DIV, so `ms0`=1 after that edge. Thereafter there is one tick every TICK_DIV running cycles.
- TICK_DIV=1 gives a tick on every running cycle starting at edge k+1.
- `stop` sampled at edge m: `running`=0 after edge m. A tick that would fall due at edge m+1 or later does not occur.
- A tick at edge m itself still occurs, because that edge is governed by `running` as registered before edge m.
- Simultaneous `start`+`stop`: `stop` wins and counting stays paused.
- `reset` with anything: a clear, effective after that edge, with `running`=0. `start` must be re-asserted after `reset` deasserts.
- `rst` asserted mid-count: immediate asynchronous clear. On `rst` deassertion the block is idle with `running`=0 and waits for `start`.
- All outputs are registered with no combinational path from inputs.

## Test plan

All scenarios use TICK_DIV=2 and a 20 ns clock period.

1. Reset: hold `rst`=0 for 50 ns with `start`=1 → all digits 0 throughout, and no counting until `rst`=1.
2. Count: release `rst`, keep `start`=1 for 250 cycles → 125 ticks, outputs `sec1`=0 `sec0`=1 `ms1`=2 `ms0`=5. The intermediate `ms0` 9→0 carry increments `ms1` on the same edge.
3. Stop/hold: after scenario 2, assert `stop` for 5 cycles → digits frozen at 01.25. Deassert `stop` and pulse `start` → counting resumes and the next tick arrives ≤2 cycles later.
4. Clear: assert `reset` while running (with `start` also high) → digits 00.00 after the edge and `running`=0. Drop `reset` and `start`, wait 10 cycles → digits still 00.00.
5. Wrap: run 6000 ticks (12000 cycles) from 00.00 → digits return to 00.00. The edge after 59.99 yields 00.00, and `sec1` never exceeds 5.
6. Priority: assert `start` and `stop` together for 10 cycles from 00.00 → no count. Assert `rst`=0 mid-count → outputs clear without waiting for a clock edge.
